cbd_coeff_collector: RTL and testbench

- Sits directly downstream of cbd_sampler.
- Consumes per-beat sampled_vals/accepted_flags and drops rejected lanes.
- Range-checks each accepted lane, converts the signed CBD value to its mod-q representative, and compacts the results into an in-order stream of N_COEFFS polynomial coefficients.
- Provides a ready handshake so the sampler controller can gate start.

---
 rtl/cbd_pkg.sv | 31 +++
 rtl/cbd_lane_compactor.sv | 52 +++++
 rtl/cbd_coeff_collector.sv | 148 ++++++++++++++
 tb/tb_cbd_coeff_collector.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbd_pkg.sv
// Shared constants, FSM state type and lane-value helpers for the CBD
// coefficient collector.
package cbd_pkg;

  localparam int Q           = 3329;
  localparam int COEFF_WIDTH = 12;
  localparam int N_COEFFS    = 256;
  localparam int IDX_W       = $clog2(N_COEFFS);
  localparam int CNT_W       = $clog2(N_COEFFS + 1);
  // Lane values are sign-extended to this width before the helpers see them.
  localparam int VAL_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_DRAIN,
    ST_DONE
  } collector_state_t;

  function automatic logic [COEFF_WIDTH-1:0] to_mod_q(input logic signed [VAL_W-1:0] v);
    logic signed [15:0] w;
    w = {{(16 - VAL_W){v[VAL_W-1]}}, v};
    if (w < 0) w = w + 16'(Q);
    return w[COEFF_WIDTH-1:0];
  endfunction

  function automatic logic in_eta(input logic signed [VAL_W-1:0] v, input int eta);
    return (int'(v) >= -eta) && (int'(v) <= eta);
  endfunction

endpackage

// File: rtl/cbd_lane_compactor.sv
// Combinational lane compactor: keeps accepted, in-range lanes in ascending
// order, converts them to mod-q form and packs them into the low slots.
module cbd_lane_compactor
  import cbd_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int CAND_BITS = 4,
  parameter int ETA       = 3
) (
  input  logic [LANES*CAND_BITS-1:0]   in_vals,
  input  logic [LANES-1:0]             in_flags,
  input  logic [CNT_W-1:0]             limit,
  output logic [LANES*COEFF_WIDTH-1:0] coeffs,
  output logic [CNT_W-1:0]             push_cnt,
  output logic                         range_viol
);

  logic [LANES-1:0]       qual;
  logic [LANES-1:0]       bad;
  logic [COEFF_WIDTH-1:0] conv [LANES];
  logic [COEFF_WIDTH-1:0] slot [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic signed [VAL_W-1:0] v_ext;
      assign v_ext = {{(VAL_W - CAND_BITS){in_vals[gi*CAND_BITS + CAND_BITS - 1]}},
                      in_vals[gi*CAND_BITS +: CAND_BITS]};
      assign qual[gi] = in_flags[gi] & in_eta(v_ext, ETA);
      assign bad[gi]  = in_flags[gi] & ~in_eta(v_ext, ETA);
      assign conv[gi] = to_mod_q(v_ext);
      assign coeffs[gi*COEFF_WIDTH +: COEFF_WIDTH] = slot[gi];
    end
  endgenerate

  // The running push count doubles as the destination slot (prefix sum).
  always_comb begin
    push_cnt = '0;
    for (int j = 0; j < LANES; j++) slot[j] = '0;
    for (int i = 0; i < LANES; i++) begin
      if (qual[i] && (push_cnt < limit)) begin
        for (int j = 0; j < LANES; j++) begin
          if (CNT_W'(j) == push_cnt) slot[j] = conv[i];
        end
        push_cnt = push_cnt + CNT_W'(1);
      end
    end
  end

  assign range_viol = |bad;

endmodule

// File: rtl/cbd_coeff_collector.sv
// Collects sampler beats into an in-order stream of N_COEFFS mod-q
// coefficients through a small circular compaction buffer.
module cbd_coeff_collector
  import cbd_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int CAND_BITS = 4,
  parameter int ETA       = 3,
  parameter int BUF_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [LANES*CAND_BITS-1:0] in_vals,
  input  logic [LANES-1:0]           in_flags,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [COEFF_WIDTH-1:0]     out_coeff,
  output logic [IDX_W-1:0]           out_index,
  output logic                       out_last,
  output logic                       poly_done,
  output logic                       range_err
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);

  collector_state_t       state_q, state_d;
  logic [COEFF_WIDTH-1:0] buf_q [BUF_DEPTH];
  logic [COEFF_WIDTH-1:0] buf_d [BUF_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [CNT_W-1:0]       pushed_cnt_q, pushed_cnt_d;
  logic [IDX_W-1:0]       index_q, index_d;
  logic                   range_err_q, range_err_d;
  logic                   poly_done_q, poly_done_d;

  logic [CNT_W-1:0]             limit;
  logic [CNT_W-1:0]             push_cnt;
  logic [CNT_W-1:0]             n_push;
  logic [LANES*COEFF_WIDTH-1:0] lane_coeffs;
  logic                         range_viol;
  logic                         accept;
  logic                         pop;

  cbd_lane_compactor #(
    .LANES    (LANES),
    .CAND_BITS(CAND_BITS),
    .ETA      (ETA)
  ) u_compactor (
    .in_vals   (in_vals),
    .in_flags  (in_flags),
    .limit     (limit),
    .coeffs    (lane_coeffs),
    .push_cnt  (push_cnt),
    .range_viol(range_viol)
  );

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= BUF_DEPTH) s = s - BUF_DEPTH;
    return PTR_W'(s);
  endfunction

  // in_ready looks only at registered occupancy, never at a same-cycle pop.
  assign limit     = CNT_W'(N_COEFFS) - pushed_cnt_q;
  assign in_ready  = (state_q == ST_COLLECT) && (occ_q <= OCC_W'(BUF_DEPTH - LANES));
  assign out_valid = (occ_q != '0);
  assign out_coeff = out_valid ? buf_q[rd_ptr_q] : '0;
  assign out_index = index_q;
  assign out_last  = out_valid && (index_q == IDX_W'(N_COEFFS - 1));
  assign poly_done = poly_done_q;
  assign range_err = range_err_q;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign n_push    = accept ? push_cnt : '0;

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q;
    pushed_cnt_d = pushed_cnt_q;
    index_d      = index_q;
    range_err_d  = range_err_q;
    poly_done_d  = 1'b0;

    if (start) begin
      state_d      = ST_COLLECT;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      occ_d        = '0;
      pushed_cnt_d = '0;
      index_d      = '0;
      range_err_d  = 1'b0;
    end else begin
      if (accept) begin
        for (int k = 0; k < LANES; k++) begin
          if (CNT_W'(k) < push_cnt)
            buf_d[ptr_add(wr_ptr_q, k)] = lane_coeffs[k*COEFF_WIDTH +: COEFF_WIDTH];
        end
        wr_ptr_d     = ptr_add(wr_ptr_q, int'(push_cnt));
        pushed_cnt_d = pushed_cnt_q + push_cnt;
        if (range_viol) range_err_d = 1'b1;
        if (pushed_cnt_d == CNT_W'(N_COEFFS)) state_d = ST_DRAIN;
      end
      if (pop) begin
        rd_ptr_d = ptr_add(rd_ptr_q, 1);
        index_d  = index_q + IDX_W'(1);
        if (out_last && (state_q == ST_DRAIN)) begin
          state_d     = ST_DONE;
          poly_done_d = 1'b1;
        end
      end
      occ_d = occ_q + OCC_W'(n_push) - OCC_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      pushed_cnt_q <= '0;
      index_q      <= '0;
      range_err_q  <= 1'b0;
      poly_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      pushed_cnt_q <= pushed_cnt_d;
      index_q      <= index_d;
      range_err_q  <= range_err_d;
      poly_done_q  <= poly_done_d;
    end
  end

endmodule

// File: tb/tb_cbd_coeff_collector.sv
// Scoreboard bench for cbd_coeff_collector: directed beats push expected
// coefficients, a negedge monitor pops and compares on each handshake.
module tb_cbd_coeff_collector;
  import cbd_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic [15:0] in_vals;
  logic [3:0]  in_flags;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_coeff;
  logic [7:0]  out_index;
  logic        out_last;
  logic        poly_done;
  logic        range_err;

  always #5 clk = ~clk;

  cbd_coeff_collector dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_vals  (in_vals),
    .in_flags (in_flags),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_coeff(out_coeff),
    .out_index(out_index),
    .out_last (out_last),
    .poly_done(poly_done),
    .range_err(range_err)
  );

  typedef struct packed {
    logic [11:0] c;
    logic [7:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_hs_cyc = -10;
  int          pd_count = 0;
  int          model_cnt = 0;
  logic        exp_rerr = 1'b0;
  logic        stall_prev = 1'b0;
  logic [11:0] st_c;
  logic [7:0]  st_i;
  logic        st_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (poly_done) begin
        chk("poly_done_timing", cyc, last_hs_cyc + 1);
        pd_count++;
      end
      if (stall_prev && out_valid) begin
        chk("stall_coeff_stable", 32'(out_coeff), 32'(st_c));
        chk("stall_index_stable", 32'(out_index), 32'(st_i));
        chk("stall_last_stable", 32'(out_last), 32'(st_l));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0d idx=%0d required=none", out_coeff, out_index);
        end else begin
          e = exp_q.pop_front();
          chk("out_coeff", 32'(out_coeff), 32'(e.c));
          chk("out_index", 32'(out_index), 32'(e.idx));
          chk("out_last", 32'(out_last), 32'(e.last));
          if (e.last) last_hs_cyc = cyc;
        end
      end
      stall_prev = out_valid && !out_ready;
      st_c = out_coeff;
      st_i = out_index;
      st_l = out_last;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_beat(input logic [15:0] v, input logic [3:0] f);
    for (int i = 0; i < 4; i++) begin
      logic signed [3:0] s;
      int sv;
      s  = v[i*4 +: 4];
      sv = s;
      if (f[i]) begin
        if (sv > 3 || sv < -3) exp_rerr = 1'b1;
        else if (model_cnt < 256) begin
          exp_q.push_back('{c: 12'(sv < 0 ? 3329 + sv : sv), idx: 8'(model_cnt),
                            last: (model_cnt == 255)});
          model_cnt++;
        end
      end
    end
  endtask

  task automatic send_beat(input logic [15:0] v, input logic [3:0] f, input bit use_model);
    int n = 0;
    while (!in_ready && n < 300) begin
      tick(1);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
      return;
    end
    in_valid = 1'b1;
    in_vals  = v;
    in_flags = f;
    if (use_model) model_beat(v, f);
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    exp_rerr  = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      tick(1);
      n++;
    end
    chk("drain_complete", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_pd(input int target, input int bound);
    int n = 0;
    while (pd_count < target && n < bound) begin
      tick(1);
      n++;
    end
    chk("poly_done_count", 32'(pd_count), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_vals   = '0;
    in_flags  = '0;
    out_ready = 1'b1;
    #1 reset = 1'b0;
    tick(2);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_coeff", 32'(out_coeff), 32'd0);
    chk("rst_out_index", 32'(out_index), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_poly_done", 32'(poly_done), 32'd0);
    chk("rst_range_err", 32'(range_err), 32'd0);
    reset = 1'b1;
    tick(1);

    // Single beat: lanes 1 (+1) and 3 (-3) accepted, hand-computed results.
    do_start();
    exp_q.push_back('{c: 12'd1, idx: 8'd0, last: 1'b0});
    exp_q.push_back('{c: 12'd3326, idx: 8'd1, last: 1'b0});
    send_beat(16'hD31F, 4'b1010, 1'b0);
    wait_drain(20);
    chk("single_range_err", 32'(range_err), 32'd0);

    // Range error is sticky until start; rejected lanes are never checked.
    do_start();
    send_beat(16'h0004, 4'b0001, 1'b1);
    chk("range_err_set", 32'(range_err), 32'd1);
    tick(5);
    chk("range_err_sticky", 32'(range_err), 32'(exp_rerr));
    chk("range_err_no_output", 32'(out_valid), 32'd0);
    do_start();
    chk("range_err_cleared", 32'(range_err), 32'd0);
    send_beat(16'h0004, 4'b0000, 1'b1);
    tick(3);
    chk("range_err_flag0", 32'(range_err), 32'd0);

    // Full polynomial of zeros.
    do_start();
    for (int b = 0; b < 64; b++) send_beat(16'h0000, 4'hF, 1'b1);
    wait_pd(1, 400);
    wait_drain(10);
    chk("full_state_done", 32'(dut.state_q), 32'(ST_DONE));
    chk("full_in_ready_done", 32'(in_ready), 32'd0);

    // Truncation at 254: only two of three qualifying lanes are kept.
    do_start();
    for (int b = 0; b < 63; b++) send_beat(16'h0000, 4'hF, 1'b1);
    send_beat(16'h0000, 4'b0011, 1'b1);
    send_beat(16'h0321, 4'b0111, 1'b1);
    chk("trunc_state_drain", 32'(dut.state_q), 32'(ST_DRAIN));
    wait_pd(2, 100);
    wait_drain(10);
    chk("trunc_state_done", 32'(dut.state_q), 32'(ST_DONE));

    // Backpressure: four full beats fill all 16 entries.
    do_start();
    out_ready = 1'b0;
    send_beat(16'h3210, 4'hF, 1'b1);
    send_beat(16'hDEF0, 4'hF, 1'b1);
    send_beat(16'h1230, 4'hF, 1'b1);
    chk("bp_ready_12", 32'(in_ready), 32'd1);
    send_beat(16'hF0F1, 4'hF, 1'b1);
    chk("bp_ready_16", 32'(in_ready), 32'd0);
    tick(4);
    out_ready = 1'b1;
    wait_drain(40);

    // Backpressure at 13 entries: 3 free slots is not enough for a beat.
    do_start();
    out_ready = 1'b0;
    send_beat(16'h1111, 4'hF, 1'b1);
    send_beat(16'hDDDD, 4'hF, 1'b1);
    send_beat(16'h0021, 4'b0011, 1'b1);
    chk("bp_ready_10", 32'(in_ready), 32'd1);
    send_beat(16'h0DD1, 4'b0111, 1'b1);
    chk("bp_ready_13", 32'(in_ready), 32'd0);
    tick(3);
    out_ready = 1'b1;
    wait_drain(40);

    // Asynchronous reset with 7 entries buffered.
    do_start();
    out_ready = 1'b0;
    send_beat(16'h3210, 4'hF, 1'b1);
    send_beat(16'h0321, 4'b0111, 1'b1);
    tick(1);
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    chk("async_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    exp_q.delete();
    model_cnt = 0;
    tick(1);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick(1);

    // Restart during COLLECT after two outputs have gone out.
    do_start();
    send_beat(16'h3210, 4'hF, 1'b1);
    tick(2);
    out_ready = 1'b0;
    chk("restart_pre_index", 32'(out_index), 32'd2);
    do_start();
    chk("restart_valid", 32'(out_valid), 32'd0);
    chk("restart_index", 32'(out_index), 32'd0);
    out_ready = 1'b1;
    send_beat(16'h0123, 4'hF, 1'b1);
    wait_drain(20);
    tick(3);
    chk("restart_no_poly_done", 32'(pd_count), 32'd2);
    chk("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
